// File: rtl/usb_host_ctrl.sv
// FT232H bridge sequencer: parses 4-byte host command packets from the RX FIFO,
// drives the register bus, and arbitrates the TX FIFO between responses and the image stream.
module usb_host_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         STREAM_BURST   = 64,
  parameter int         TX_FIFO_DEPTH  = 512
) (
  input  logic       clk_i,
  input  logic       nrst,
  output logic       rxf_rdreq_o,
  input  logic [7:0] rxf_rddata_i,
  input  logic [8:0] rxf_rdusedw_i,
  output logic       txe_wrreq_o,
  output logic [7:0] txe_wrdata_o,
  input  logic [8:0] txe_wrusedw_i,
  input  logic       txe_wrfull_i,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  input  logic [7:0] reg_rdata_i,
  input  logic       strm_valid_i,
  input  logic [7:0] strm_data_i,
  output logic       strm_ready_o,
  output logic       cmd_err_o,
  output logic       busy_o
);

  localparam int          DATA_W     = 8;
  localparam logic [7:0]  OP_WR      = 8'h01;
  localparam logic [7:0]  OP_RD      = 8'h02;
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  BURST_LAST = 9'(STREAM_BURST - 1);
  localparam logic [9:0]  ROOM_MAX   = 10'(TX_FIFO_DEPTH - 4);

  typedef enum logic [2:0] {
    P_HUNT, P_OP, P_ADDR, P_DATA, P_EXEC, P_RDCAP, P_RESP
  } p_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_RESP, T_STRM
  } t_state_t;

  p_state_t p_state, p_next;
  t_state_t t_state, t_next;

  logic              rx_vld_p1;
  logic [15:0]       tmo_cnt;
  logic              resp_pend;
  logic [1:0]        resp_idx;
  logic [8:0]        burst_cnt;

  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] resp_b3_q;
  logic [DATA_W-1:0] resp_byte;

  logic rx_fetch;
  logic resp_load;
  logic resp_last;
  logic strm_xfer;
  logic tmo_run;

  // ---- fetch stage p0: one read request at a time, data lands in p1
  assign rxf_rdreq_o = nrst & rx_fetch & (rxf_rdusedw_i != '0) & ~rx_vld_p1;
  assign busy_o      = (p_state != P_HUNT);

  always_comb begin
    p_next    = p_state;
    rx_fetch  = 1'b0;
    reg_wr_o  = 1'b0;
    reg_rd_o  = 1'b0;
    cmd_err_o = 1'b0;
    resp_load = 1'b0;
    case (p_state)
      P_HUNT: begin
        rx_fetch = 1'b1;
        if (rx_vld_p1 && (rxf_rddata_i == SYNC_BYTE)) p_next = P_OP;
      end
      P_OP: begin
        rx_fetch = 1'b1;
        if (rx_vld_p1) p_next = P_ADDR;
        else if (tmo_cnt == TMO_LAST) begin
          cmd_err_o = 1'b1;
          p_next    = P_HUNT;
        end
      end
      P_ADDR: begin
        rx_fetch = 1'b1;
        if (rx_vld_p1) p_next = P_DATA;
        else if (tmo_cnt == TMO_LAST) begin
          cmd_err_o = 1'b1;
          p_next    = P_HUNT;
        end
      end
      P_DATA: begin
        rx_fetch = 1'b1;
        if (rx_vld_p1) p_next = P_EXEC;
        else if (tmo_cnt == TMO_LAST) begin
          cmd_err_o = 1'b1;
          p_next    = P_HUNT;
        end
      end
      P_EXEC: begin
        if (op_q == OP_WR) begin
          reg_wr_o  = 1'b1;
          resp_load = 1'b1;
          p_next    = P_RESP;
        end else if (op_q == OP_RD) begin
          reg_rd_o = 1'b1;
          p_next   = P_RDCAP;
        end else begin
          cmd_err_o = 1'b1;
          p_next    = P_HUNT;
        end
      end
      P_RDCAP: begin
        resp_load = 1'b1;
        p_next    = P_RESP;
      end
      P_RESP: begin
        if (!resp_pend) p_next = P_HUNT;
      end
      default: p_next = P_HUNT;
    endcase
  end

  // Address/data only leave the block during a strobe so the bus idles at zero.
  assign reg_addr_o  = (reg_wr_o | reg_rd_o) ? addr_q : '0;
  assign reg_wdata_o = reg_wr_o ? data_q : '0;

  assign tmo_run = ((p_state == P_OP) || (p_state == P_ADDR) || (p_state == P_DATA))
                   && (p_next == p_state) && !rx_vld_p1;

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      p_state   <= P_HUNT;
      rx_vld_p1 <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      p_state   <= p_next;
      rx_vld_p1 <= rxf_rdreq_o;
      tmo_cnt   <= tmo_run ? tmo_cnt + 16'd1 : '0;
    end
  end

  // ---- capture stage p1: packet fields and response payload
  always_ff @(posedge clk_i) begin
    if (rx_vld_p1) begin
      case (p_state)
        P_OP:    op_q   <= rxf_rddata_i;
        P_ADDR:  addr_q <= rxf_rddata_i;
        P_DATA:  data_q <= rxf_rddata_i;
        default: ;
      endcase
    end
    if (resp_load) resp_b3_q <= (p_state == P_RDCAP) ? reg_rdata_i : data_q;
  end

  always_comb begin
    case (resp_idx)
      2'd0:    resp_byte = SYNC_BYTE;
      2'd1:    resp_byte = op_q | 8'h80;
      2'd2:    resp_byte = addr_q;
      default: resp_byte = resp_b3_q;
    endcase
  end

  // ---- TX arbiter: response is atomic and outranks the stream
  always_comb begin
    t_next       = t_state;
    txe_wrreq_o  = 1'b0;
    txe_wrdata_o = '0;
    strm_ready_o = 1'b0;
    resp_last    = 1'b0;
    strm_xfer    = 1'b0;
    case (t_state)
      T_IDLE: begin
        if (resp_pend) begin
          if ({1'b0, txe_wrusedw_i} <= ROOM_MAX) t_next = T_RESP;
        end else if (strm_valid_i && !txe_wrfull_i) begin
          t_next = T_STRM;
        end
      end
      T_RESP: begin
        if (!txe_wrfull_i) begin
          txe_wrreq_o  = 1'b1;
          txe_wrdata_o = resp_byte;
          if (resp_idx == 2'd3) begin
            resp_last = 1'b1;
            t_next    = T_IDLE;
          end
        end
      end
      T_STRM: begin
        strm_ready_o = ~txe_wrfull_i;
        if (!strm_valid_i) t_next = T_IDLE;
        else if (!txe_wrfull_i) begin
          strm_xfer    = 1'b1;
          txe_wrreq_o  = 1'b1;
          txe_wrdata_o = strm_data_i;
          if (burst_cnt == BURST_LAST) t_next = T_IDLE;
        end
      end
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      t_state   <= T_IDLE;
      resp_pend <= 1'b0;
      resp_idx  <= '0;
      burst_cnt <= '0;
    end else begin
      t_state <= t_next;
      if (resp_load)      resp_pend <= 1'b1;
      else if (resp_last) resp_pend <= 1'b0;
      if ((t_state == T_RESP) && txe_wrreq_o) resp_idx <= resp_idx + 2'd1;
      if (t_state != T_STRM) burst_cnt <= '0;
      else if (strm_xfer)    burst_cnt <= burst_cnt + 9'd1;
    end
  end

endmodule

// File: tb/tb_usb_host_ctrl.sv
// Directed bench for usb_host_ctrl: FIFO, register-bus and stream source models with a TX log.
module tb_usb_host_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rxf_rdreq;
  logic [7:0] rxf_rddata = 8'h00;
  logic [8:0] rxf_rdusedw;
  logic       txe_wrreq;
  logic [7:0] txe_wrdata;
  logic [8:0] tx_usedw = 9'd0;
  logic       tx_full = 1'b0;
  logic       reg_wr, reg_rd;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       strm_valid = 1'b0;
  logic [7:0] strm_seq = 8'h00;
  logic       strm_ready;
  logic       cmd_err, busy;

  always #5 clk = ~clk;

  usb_host_ctrl dut (
    .clk_i(clk), .nrst(nrst),
    .rxf_rdreq_o(rxf_rdreq), .rxf_rddata_i(rxf_rddata), .rxf_rdusedw_i(rxf_rdusedw),
    .txe_wrreq_o(txe_wrreq), .txe_wrdata_o(txe_wrdata),
    .txe_wrusedw_i(tx_usedw), .txe_wrfull_i(tx_full),
    .reg_wr_o(reg_wr), .reg_rd_o(reg_rd), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
    .reg_rdata_i(reg_rdata),
    .strm_valid_i(strm_valid), .strm_data_i(strm_seq), .strm_ready_o(strm_ready),
    .cmd_err_o(cmd_err), .busy_o(busy)
  );

  logic [30:0] outs;
  assign outs = {rxf_rdreq, txe_wrreq, txe_wrdata, reg_wr, reg_rd, reg_addr, reg_wdata,
                 strm_ready, cmd_err, busy};

  // RX FIFO model, non-showahead
  logic [7:0] rxmem [0:255];
  logic [7:0] rx_wp = 8'd0;
  logic [7:0] rx_rp = 8'd0;
  assign rxf_rdusedw = {1'b0, 8'(rx_wp - rx_rp)};

  always @(posedge clk) begin
    if (rxf_rdreq && (rx_wp != rx_rp)) begin
      rxf_rddata <= rxmem[rx_rp];
      rx_rp      <= rx_rp + 8'd1;
    end
  end

  logic [7:0] rd_val = 8'h00;
  always @(posedge clk) reg_rdata <= reg_rd ? rd_val : 8'hEE;

  always @(posedge clk) if (strm_valid && strm_ready) strm_seq <= strm_seq + 8'd1;

  // Mid-cycle monitor
  logic [7:0] txlog [0:4095];
  int tx_n = 0, wr_n = 0, rd_n = 0, err_n = 0, uf_n = 0, of_n = 0;
  logic [7:0] last_waddr = 8'h00, last_wdata = 8'h00, last_raddr = 8'h00;

  always @(negedge clk) begin
    if (txe_wrreq) begin
      txlog[12'(tx_n)] <= txe_wrdata;
      tx_n <= tx_n + 1;
    end
    if (reg_wr) begin
      wr_n <= wr_n + 1;
      last_waddr <= reg_addr;
      last_wdata <= reg_wdata;
    end
    if (reg_rd) begin
      rd_n <= rd_n + 1;
      last_raddr <= reg_addr;
    end
    if (cmd_err) err_n <= err_n + 1;
    if (rxf_rdreq && (rxf_rdusedw == 9'd0)) uf_n <= uf_n + 1;
    if (txe_wrreq && tx_full) of_n <= of_n + 1;
  end

  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rxmem[rx_wp] = b;
    rx_wp = rx_wp + 8'd1;
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    push(b0); push(b1); push(b2); push(b3);
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    check({tag, "_b0"}, 32'(txlog[12'(base)]),     32'(b0));
    check({tag, "_b1"}, 32'(txlog[12'(base + 1)]), 32'(b1));
    check({tag, "_b2"}, 32'(txlog[12'(base + 2)]), 32'(b2));
    check({tag, "_b3"}, 32'(txlog[12'(base + 3)]), 32'(b3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, w0, r0, e0, t0;
    logic [7:0] s0;

    step(3);
    check("reset_outputs", 32'(outs), 32'd0);
    nrst = 1'b1;
    step(2);

    // write command
    b = tx_n; w0 = wr_n; r0 = rd_n;
    push4(8'hA5, 8'h01, 8'h10, 8'h3C);
    step(40);
    check("wr_strobes", 32'(wr_n - w0), 32'd1);
    check("wr_no_rd", 32'(rd_n - r0), 32'd0);
    check("wr_addr", 32'(last_waddr), 32'h10);
    check("wr_wdata", 32'(last_wdata), 32'h3C);
    check("wr_tx_count", 32'(tx_n - b), 32'd4);
    chk_bytes("wr_resp", b, 8'hA5, 8'h81, 8'h10, 8'h3C);
    check("wr_busy_done", 32'(busy), 32'd0);

    // read command
    b = tx_n; w0 = wr_n; r0 = rd_n;
    rd_val = 8'h5A;
    push4(8'hA5, 8'h02, 8'h22, 8'h00);
    step(40);
    check("rd_strobes", 32'(rd_n - r0), 32'd1);
    check("rd_no_wr", 32'(wr_n - w0), 32'd0);
    check("rd_addr", 32'(last_raddr), 32'h22);
    check("rd_tx_count", 32'(tx_n - b), 32'd4);
    chk_bytes("rd_resp", b, 8'hA5, 8'h82, 8'h22, 8'h5A);

    // garbage then bad opcode
    b = tx_n; w0 = wr_n; r0 = rd_n; e0 = err_n;
    push(8'h00); push(8'hFF);
    push4(8'hA5, 8'h07, 8'h00, 8'h00);
    step(50);
    check("badop_err", 32'(err_n - e0), 32'd1);
    check("badop_no_wr", 32'(wr_n - w0), 32'd0);
    check("badop_no_rd", 32'(rd_n - r0), 32'd0);
    check("badop_no_tx", 32'(tx_n - b), 32'd0);
    check("badop_rx_drained", 32'(rxf_rdusedw), 32'd0);
    check("badop_busy", 32'(busy), 32'd0);

    // truncated packet times out, next packet executes
    e0 = err_n;
    push(8'hA5); push(8'h01);
    step(900);
    check("tmo_not_early", 32'(err_n - e0), 32'd0);
    check("tmo_busy_waiting", 32'(busy), 32'd1);
    step(120);
    check("tmo_err", 32'(err_n - e0), 32'd1);
    check("tmo_busy_cleared", 32'(busy), 32'd0);
    b = tx_n; w0 = wr_n;
    push4(8'hA5, 8'h01, 8'h05, 8'h09);
    step(40);
    check("tmo_next_wr", 32'(wr_n - w0), 32'd1);
    check("tmo_next_addr", 32'(last_waddr), 32'h05);
    check("tmo_next_wdata", 32'(last_wdata), 32'h09);
    chk_bytes("tmo_next_resp", b, 8'hA5, 8'h81, 8'h05, 8'h09);

    // TX room check
    tx_usedw = 9'd510;
    rd_val = 8'hC3;
    b = tx_n;
    push4(8'hA5, 8'h02, 8'h33, 8'h00);
    step(40);
    check("room510_no_tx", 32'(tx_n - b), 32'd0);
    check("room510_busy", 32'(busy), 32'd1);
    tx_usedw = 9'd509;
    step(20);
    check("room509_no_tx", 32'(tx_n - b), 32'd0);
    tx_usedw = 9'd508;
    step(20);
    check("room508_tx_count", 32'(tx_n - b), 32'd4);
    chk_bytes("room508_resp", b, 8'hA5, 8'h82, 8'h33, 8'hC3);
    check("room508_busy", 32'(busy), 32'd0);
    tx_usedw = 9'd0;

    // full FIFO blocks the stream
    b = tx_n;
    tx_full = 1'b1;
    strm_valid = 1'b1;
    step(10);
    check("full_no_tx", 32'(tx_n - b), 32'd0);
    check("full_not_ready", 32'(strm_ready), 32'd0);
    strm_valid = 1'b0;
    tx_full = 1'b0;
    step(3);

    // stream burst with read arriving mid-burst
    b = tx_n; s0 = strm_seq;
    strm_valid = 1'b1;
    for (int i = 0; i < 200 && (tx_n - b) < 20; i++) step(1);
    rd_val = 8'h5A;
    push4(8'hA5, 8'h02, 8'h22, 8'h00);
    for (int i = 0; i < 400 && (tx_n - b) < 80; i++) step(1);
    strm_valid = 1'b0;
    step(5);
    check("strm_enough_bytes", 32'((tx_n - b) >= 80), 32'd1);
    for (int i = 0; i < 64; i++)
      check("strm_burst_byte", 32'(txlog[12'(b + i)]), 32'(8'(s0 + 8'(i))));
    chk_bytes("strm_resp", b + 64, 8'hA5, 8'h82, 8'h22, 8'h5A);
    check("strm_resume0", 32'(txlog[12'(b + 68)]), 32'(8'(s0 + 8'd64)));
    check("strm_resume1", 32'(txlog[12'(b + 69)]), 32'(8'(s0 + 8'd65)));

    // asynchronous reset mid-burst and mid-packet
    t0 = tx_n;
    strm_valid = 1'b1;
    step(10);
    check("pre_rst_streaming", 32'((tx_n - t0) > 0), 32'd1);
    push(8'hA5); push(8'h01);
    nrst = 1'b0;
    #1;
    check("rst_mid_outputs", 32'(outs), 32'd0);
    step(2);
    check("rst_held_outputs", 32'(outs), 32'd0);
    strm_valid = 1'b0;
    nrst = 1'b1;
    step(5);

    check("no_rx_underflow", 32'(uf_n), 32'd0);
    check("no_wr_while_full", 32'(of_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
